// File: rtl/tvp_pkg.sv
// Shared types and helpers for the TVP frame packer.
package tvp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_888 = 1'b0;
    localparam logic MODE_565 = 1'b1;

    // Channels arrive MSB-aligned in 10 bits so one helper serves every COLOR_BITS.
    function automatic logic [15:0] pack565(input logic [9:0] r, input logic [9:0] g,
                                            input logic [9:0] b);
        return {r[9:5], g[9:4], b[9:5]};
    endfunction

endpackage

// File: rtl/tvp_frame_packer_sync_fifo.sv
// Packed-word FIFO with combinational head read and synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // A push into a full FIFO is still taken when the head leaves the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign level   = LW'(wr_ptr - rd_ptr);
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush wins over any concurrent push/pop.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge gclk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tvp_frame_packer.sv
// Captures TVP pixels on sample_clock edges, packs them into 32-bit words and
// streams them as sequential SDRAM writes from BASE_ADDR for NUM_WORDS words.
module tvp_frame_packer
    import tvp_pkg::*;
#(
    parameter int COLOR_BITS = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 23,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [COLOR_BITS-1:0] r,
    input  logic [COLOR_BITS-1:0] g,
    input  logic [COLOR_BITS-1:0] b,
    input  logic                  sample_clock,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  rw,
    output logic [31:0]           data_out,
    input  logic                  busy,
    output logic                  in_valid,
    output logic                  done,
    output logic                  overflow,
    output logic [7:0]            leds
);

    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam int SH    = 10 - COLOR_BITS;

    state_e             state_q, state_d;
    logic [2:0]         sync_pipe;
    logic               ev_q, sample_ev, armed;
    logic               mode_q;
    logic               half_valid;
    logic [15:0]        half_data, pix16;
    logic               push, accept, flush;
    logic [31:0]        push_data;
    logic               fifo_full, fifo_empty;
    logic [LW-1:0]      fifo_level;
    logic [6:0]         lvl_ext;
    logic [4:0]         lvl_sat;
    logic [CNT_W-1:0]   count_q;
    logic               last_word;

    // Two-flop synchroniser plus a third flop for edge detection; the event is
    // registered so it lands 3 clk after the strobe edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_pipe <= '0;
            ev_q      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], sample_clock};
            ev_q      <= sync_pipe[1] & ~sync_pipe[2];
        end
    end

    assign armed     = (state_q == RUN);
    assign sample_ev = ev_q && armed && !start;

    assign pix16 = pack565(10'(r) << SH, 10'(g) << SH, 10'(b) << SH);

    // Select what (if anything) a sample event pushes into the FIFO.
    always_comb begin
        push      = 1'b0;
        push_data = 32'({r, g, b});
        if (sample_ev) begin
            if (mode_q == MODE_888) begin
                push = 1'b1;
            end else if (half_valid) begin
                push      = 1'b1;
                push_data = {pix16, half_data};
            end
        end
    end

    // RGB565 half latch holds the first pixel of each pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_valid <= 1'b0;
            half_data  <= '0;
        end else if (start || state_q == DONE) begin
            half_valid <= 1'b0;
        end else if (sample_ev && mode_q == MODE_565) begin
            half_valid <= !half_valid;
            if (!half_valid) half_data <= pix16;
        end
    end

    assign in_valid = armed && !fifo_empty;
    assign rw       = in_valid;
    assign accept   = in_valid && !busy;
    assign flush    = start || (state_q == DONE);

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .gclk   (clk),
        .grst_n (rst),
        .flush  (flush),
        .push   (push),
        .wdata  (push_data),
        .pop    (accept),
        .rdata  (data_out),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // Start re-arms the capture; accepts advance address and word count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= '0;
            count_q  <= '0;
            mode_q   <= MODE_888;
            overflow <= 1'b0;
        end else if (start) begin
            addr     <= ADDR_WIDTH'(BASE_ADDR);
            count_q  <= '0;
            mode_q   <= mode;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                addr    <= addr + 1'b1;
                count_q <= count_q + 1'b1;
            end
            if (push && fifo_full && !accept) overflow <= 1'b1;
        end
    end

    assign last_word = (count_q == CNT_W'(NUM_WORDS - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: start always (re)enters RUN, the last accept ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (start)                    state_d = RUN;
                else if (accept && last_word) state_d = DONE;
            end
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign done    = (state_q == DONE);
    assign lvl_ext = 7'(fifo_level);
    assign lvl_sat = (lvl_ext > 7'd31) ? 5'd31 : lvl_ext[4:0];
    assign leds    = {done, overflow, armed, lvl_sat};

endmodule

// File: tb/tb_tvp_frame_packer.sv
// Directed bench: one DUT with a 4-bit address space, BASE_ADDR=15, NUM_WORDS=3
// and a 2-deep FIFO so wrap, overflow and restart all show up in one run.
module tb_tvp_frame_packer;

    localparam int CB = 8;
    localparam int FD = 2;
    localparam int AW = 4;
    localparam int BA = 15;
    localparam int NW = 3;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
    logic          sample_clock = 1'b0, busy = 1'b0;
    logic [CB-1:0] r = '0, g = '0, b = '0;
    logic [AW-1:0] addr;
    logic          rw, in_valid, done, overflow;
    logic [31:0]   data_out;
    logic [7:0]    leds;

    int tests = 0, fails = 0;
    int lat;
    logic stable;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    always #5 clk = ~clk;

    tvp_frame_packer #(
        .COLOR_BITS(CB), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW),
        .BASE_ADDR(BA), .NUM_WORDS(NW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .r(r), .g(g), .b(b), .sample_clock(sample_clock),
        .addr(addr), .rw(rw), .data_out(data_out), .busy(busy),
        .in_valid(in_valid), .done(done), .overflow(overflow), .leds(leds)
    );

    // Record every accepted write (busy only changes just after posedge).
    always @(negedge clk) begin
        if (rst && in_valid && !busy) begin
            wa.push_back(addr);
            wd.push_back(data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Strobe high 3 clk, low 3 clk; lat = first cycle in_valid was seen, else -1.
    task automatic pulse(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                         output int l);
        r = rr; g = gg; b = bb;
        sample_clock = 1'b1;
        l = -1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 3) sample_clock = 1'b0;
            if (in_valid && l < 0) l = k;
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] d);
        if (idx < wa.size()) begin
            check({tag, "_addr"}, 32'(wa[idx]), a);
            check({tag, "_data"}, wd[idx], d);
        end else begin
            check({tag, "_count"}, 32'(wa.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_in_valid", 32'(in_valid), 0);
        check("rst_rw", 32'(rw), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_leds", 32'(leds), 0);
        rst = 1'b1;

        // RGB888, wrap 15 -> 0 -> 1, then done
        do_start(1'b0);
        check("a_leds_armed", 32'(leds), 32'h20);
        check("a_addr_base", 32'(addr), 15);
        pulse(8'h01, 8'h02, 8'h03, lat);
        check("a_latency", 32'(lat), 4);
        pulse(8'h04, 8'h05, 8'h06, lat);
        pulse(8'h07, 8'h08, 8'h09, lat);
        step(2);
        check("a_done", 32'(done), 1);
        check("a_leds_done", 32'(leds), 32'h80);
        check("a_nwrites", 32'(wa.size()), 3);
        chk_wr("a_w0", 0, 15, 32'h00010203);
        chk_wr("a_w1", 1, 0, 32'h00040506);
        chk_wr("a_w2", 2, 1, 32'h00070809);
        pulse(8'h0A, 8'h0B, 8'h0C, lat);
        check("a_after_done_lat", 32'(lat), 32'hFFFF_FFFF);
        check("a_after_done_n", 32'(wa.size()), 3);

        // RGB565, two pixels per word
        do_start(1'b1);
        check("b_done_cleared", 32'(done), 0);
        pulse(8'hFF, 8'h00, 8'h00, lat);
        check("b_half_no_write", 32'(lat), 32'hFFFF_FFFF);
        pulse(8'h00, 8'h00, 8'hFF, lat);
        check("b_pair_latency", 32'(lat), 4);
        pulse(8'h10, 8'h20, 8'h30, lat);
        pulse(8'h40, 8'h80, 8'hC0, lat);
        pulse(8'hFF, 8'hFF, 8'hFF, lat);
        pulse(8'h00, 8'h00, 8'h00, lat);
        step(2);
        check("b_done", 32'(done), 1);
        check("b_nwrites", 32'(wa.size()), 6);
        chk_wr("b_w0", 3, 15, 32'h001FF800);
        chk_wr("b_w1", 4, 0, 32'h44181106);
        chk_wr("b_w2", 5, 1, 32'h0000FFFF);

        // Busy stall holds the request stable
        do_start(1'b0);
        busy = 1'b1;
        pulse(8'hAA, 8'hBB, 8'hCC, lat);
        check("c_req_valid", 32'(in_valid), 1);
        check("c_req_rw", 32'(rw), 1);
        check("c_req_addr", 32'(addr), 15);
        check("c_req_data", data_out, 32'h00AABBCC);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (!(in_valid && rw && addr == 4'd15 && data_out == 32'h00AABBCC)) stable = 1'b0;
        end
        check("c_stable", 32'(stable), 1);
        check("c_no_accept", 32'(wa.size()), 6);
        busy = 1'b0;
        step(1);
        check("c_addr_inc", 32'(addr), 0);
        check("c_valid_drop", 32'(in_valid), 0);
        check("c_one_accept", 32'(wa.size()), 7);
        chk_wr("c_w", 6, 15, 32'h00AABBCC);

        // Overflow with a 2-deep FIFO while busy
        busy = 1'b1;
        pulse(8'h11, 8'h11, 8'h11, lat);
        pulse(8'h22, 8'h22, 8'h22, lat);
        pulse(8'h33, 8'h33, 8'h33, lat);
        check("d_overflow", 32'(overflow), 1);
        check("d_leds", 32'(leds), 32'h62);
        busy = 1'b0;
        step(4);
        check("d_done", 32'(done), 1);
        check("d_overflow_sticky", 32'(overflow), 1);
        check("d_leds_done", 32'(leds), 32'hC0);
        check("d_nwrites", 32'(wa.size()), 9);
        chk_wr("d_w0", 7, 0, 32'h00111111);
        chk_wr("d_w1", 8, 1, 32'h00222222);

        // Restart clears overflow; async reset mid-request
        do_start(1'b0);
        check("e_overflow_clr", 32'(overflow), 0);
        check("e_addr_base", 32'(addr), 15);
        check("e_leds", 32'(leds), 32'h20);
        busy = 1'b1;
        pulse(8'h01, 8'h01, 8'h01, lat);
        pulse(8'h02, 8'h02, 8'h02, lat);
        pulse(8'h03, 8'h03, 8'h03, lat);
        check("e_pre_overflow", 32'(overflow), 1);
        check("e_pre_valid", 32'(in_valid), 1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("e_rst_valid", 32'(in_valid), 0);
        check("e_rst_addr", 32'(addr), 0);
        check("e_rst_done", 32'(done), 0);
        check("e_rst_overflow", 32'(overflow), 0);
        check("e_rst_leds", 32'(leds), 0);
        step(1);
        rst  = 1'b1;
        busy = 1'b0;
        pulse(8'h05, 8'h05, 8'h05, lat);
        step(2);
        check("e_idle_lat", 32'(lat), 32'hFFFF_FFFF);
        check("e_idle_nwrites", 32'(wa.size()), 9);

        // Fresh start after reset
        do_start(1'b0);
        pulse(8'h12, 8'h34, 8'h56, lat);
        check("f_latency", 32'(lat), 4);
        step(2);
        check("f_nwrites", 32'(wa.size()), 10);
        chk_wr("f_w", 9, 15, 32'h00123456);
        check("f_not_done", 32'(done), 0);
        check("f_leds", 32'(leds), 32'h20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tvp_frame_packer.md
Name: tvp_frame_packer

Overview:
Parametrised successor to the TVP sampler. It synchronises the TVP sample_clock and captures r/g/b on each rising edge. Pixels are packed into 32-bit words, either as RGB888 (one pixel per word) or RGB565 (two pixels per word). Packed words are buffered in a small FIFO and streamed as sequential writes to the SDRAM controller, starting at a base address, until a programmed word count is reached.

Parameters:
COLOR_BITS, 8, width of each of r/g/b; legal range 6..10, with 3*COLOR_BITS <= 32.
FIFO_DEPTH, 8, packed-word FIFO depth; power of two, 2..64.
ADDR_WIDTH, 23, SDRAM word address width.
BASE_ADDR, 0, first write address after start.
NUM_WORDS, 1024, words written per capture; 1..2^ADDR_WIDTH.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; arms (or re-arms) a capture
mode  in  1  0 = RGB888 one pixel/word; 1 = RGB565 two pixels/word; latched on start
r  in  COLOR_BITS  red channel from TVP
g  in  COLOR_BITS  green channel from TVP
b  in  COLOR_BITS  blue channel from TVP
sample_clock  in  1  TVP pixel strobe, asynchronous to clk
addr  out  ADDR_WIDTH  SDRAM write address
rw  out  1  1 = write; held 1 whenever in_valid=1
data_out  out  32  SDRAM write data
busy  in  1  controller busy; request accepted when in_valid && !busy
in_valid  out  1  write request valid
done  out  1  NUM_WORDS written
overflow  out  1  sticky; a packed word was dropped because the FIFO was full
leds  out  8  {done, overflow, armed, fifo_level[4:0] saturated at 31}

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, addr=0, FIFO empty, pack latch empty, FSM=IDLE, armed=0.
- sample_clock synchroniser:
  - 2-FF synchroniser, then a rising-edge detector.
  - A sample event occurs in the cycle after the edge reaches the 2nd FF, i.e. 3 clk cycles after the edge.
  - r/g/b are captured in that cycle; they are stable for >= 4 clk around the pulse.
  - Events are ignored unless armed=1.
- Packing:
  - mode 0: word = zero-extended {r,g,b}, r in the MSBs. One FIFO push per event.
  - mode 1: pix16 = {r[CB-1:CB-5], g[CB-1:CB-6], b[CB-1:CB-5]}.
    - 1st event: pix16 goes into the half latch.
    - 2nd event: push {pix16_2, pix16_1}; the first pixel is in bits [15:0].
- FIFO:
  - Push with FIFO full: word dropped, overflow<=1.
  - Simultaneous push and pop while full is allowed; no drop.
- Start:
  - Clears the FIFO, half latch, overflow and done; word count=0; addr=BASE_ADDR; latches mode; armed=1.
  - start during an active capture restarts immediately.
  - An outstanding request is dropped after its current handshake cycle; the controller sees in_valid fall.
- Write FSM:
  - IDLE: armed=0, in_valid=0. Go to RUN on start.
  - RUN: when the FIFO is non-empty, present the head word on data_out with addr, rw=1, in_valid=1. Hold all of these stable until a cycle with !busy.
    - In the accept cycle: pop, addr+1, count+1.
    - The next request may issue in the following cycle, giving a peak throughput of 1 word/clk.
  - After accepting word NUM_WORDS: go to DONE; armed=0; in_valid=0 the next cycle.
  - DONE: done=1; sample events ignored; residual FIFO and half-latch contents discarded. Go to RUN on start.
- Address:
  - Wraps modulo 2^ADDR_WIDTH.
  - A capture that crosses the top of memory continues at address 0.
- Latency: sample edge to in_valid is 4 clk in mode 0 when the FIFO is empty and the FSM is in RUN.

Decomposition:
- Package tvp_pkg holds:
  - FSM state encodings IDLE/RUN/DONE.
  - Function pack565(r,g,b).
  - Mode constants MODE_888=0 and MODE_565=1.
- One sub-module: sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH), with outputs full, empty and level, and a synchronous flush input.

Test Plan:
1. mode 0, COLOR_BITS=8, NUM_WORDS=2, busy=0: start; pulse sample_clock with r=01,g=02,b=03, then r=04,g=05,b=06 -> writes 32'h00010203 @0 and 32'h00040506 @1; done=1; further pulses produce no in_valid.
2. mode 1, NUM_WORDS=1: pulses with r=FF,g=00,b=00, then r=00,g=00,b=FF -> single write 32'h001FF800 @BASE_ADDR; done=1.
3. busy held 1 for 10 cycles during a request -> addr, data_out and in_valid stay stable; exactly one accept when busy falls; addr increments by 1.
4. FIFO_DEPTH=2, busy=1, 3 pulses in mode 0 -> overflow=1, leds[6]=1; after busy drops, exactly 2 writes are seen.
5. rst driven low mid-request, asynchronously between clk edges -> in_valid, addr, done and overflow are 0 immediately; no writes until the next start.
6. ADDR_WIDTH=4, BASE_ADDR=15, NUM_WORDS=3 -> writes to addresses 15, 0, 1; a start pulse after done re-runs from address 15 with overflow cleared.
